// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor-core K-loop sequencer and its 4x4 FP16 MMA datapath.
package tensor_core_pkg;

    localparam int DWIDTH = 16;
    localparam int AWIDTH = 91;

    typedef logic [0:3][0:3][DWIDTH-1:0] fp_tile_t;
    typedef logic [0:3][0:3][AWIDTH-1:0] acc_tile_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        OUT   = 2'd3
    } kseq_state_t;

endpackage

// File: rtl/tensor_core_kseq.sv
// K-loop sequencer: streams A/B tile pairs into an external MMA datapath and
// keeps the Kulisch accumulator tile in registers between passes.
module tensor_core_kseq #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 91,
    parameter int KW     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [KW-1:0]                 k_tiles,
    input  logic                          c_init_sel,
    input  logic [0:3][0:3][AWIDTH-1:0]   c_init,
    output logic                          busy,
    input  logic                          tile_valid,
    output logic                          tile_ready,
    input  logic [0:3][0:3][DWIDTH-1:0]   a_tile,
    input  logic [0:3][0:3][DWIDTH-1:0]   b_tile,
    output logic [0:3][0:3][DWIDTH-1:0]   gemm_a,
    output logic [0:3][0:3][DWIDTH-1:0]   gemm_b,
    output logic [0:3][0:3][AWIDTH-1:0]   gemm_c,
    input  logic [0:3][0:3][AWIDTH-1:0]   gemm_result,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [0:3][0:3][AWIDTH-1:0]   res_data,
    output logic [KW-1:0]                 tile_cnt
);
    import tensor_core_pkg::*;

    kseq_state_t                  state;
    logic [0:3][0:3][AWIDTH-1:0]  acc;
    logic [0:3][0:3][DWIDTH-1:0]  a_reg;
    logic [0:3][0:3][DWIDTH-1:0]  b_reg;
    logic [KW-1:0]                remaining;

    // rst_n is active-high despite its name; it abandons any job in flight.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            remaining <= '0;
            tile_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= k_tiles;
                        tile_cnt  <= '0;
                        acc       <= c_init_sel ? c_init : '0;
                        state     <= (k_tiles == '0) ? OUT : FETCH;
                    end
                end
                FETCH: begin
                    if (tile_valid) begin
                        a_reg <= a_tile;
                        b_reg <= b_tile;
                        state <= MAC;
                    end
                end
                MAC: begin
                    // The datapath sees a_reg/b_reg/acc this cycle; capture its C_out.
                    acc       <= gemm_result;
                    remaining <= remaining - KW'(1);
                    tile_cnt  <= tile_cnt + KW'(1);
                    state     <= (remaining == KW'(1)) ? OUT : FETCH;
                end
                OUT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign tile_ready = (state == FETCH);
    assign res_valid  = (state == OUT);
    assign gemm_a     = a_reg;
    assign gemm_b     = b_reg;
    assign gemm_c     = acc;
    assign res_data   = acc;

endmodule

// File: tb/tb_tensor_core_kseq.sv
// Bench for tensor_core_kseq with a stand-in datapath (C+1 stub or a small FP16 MMA model).
module tb_tensor_core_kseq;
    import tensor_core_pkg::*;

    localparam int KW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic [KW-1:0]        k_tiles = '0;
    logic                 c_init_sel = 1'b0;
    acc_tile_t            c_init = '0;
    logic                 busy;
    logic                 tile_valid = 1'b0;
    logic                 tile_ready;
    fp_tile_t             a_tile = '0;
    fp_tile_t             b_tile = '0;
    fp_tile_t             gemm_a;
    fp_tile_t             gemm_b;
    acc_tile_t            gemm_c;
    acc_tile_t            gemm_result;
    logic                 res_valid;
    logic                 res_ready = 1'b1;
    acc_tile_t            res_data;
    logic [KW-1:0]        tile_cnt;

    bit                   int_mode = 1'b0;
    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   rdy_total = 0;
    acc_tile_t            exp_q[$];

    tensor_core_kseq #(.DWIDTH(16), .AWIDTH(91), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_tiles(k_tiles),
        .c_init_sel(c_init_sel), .c_init(c_init), .busy(busy),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .a_tile(a_tile), .b_tile(b_tile),
        .gemm_a(gemm_a), .gemm_b(gemm_b), .gemm_c(gemm_c),
        .gemm_result(gemm_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tile_ready) rdy_total++;
    end

    // Positive normal FP16 to fixed point with LSB = 2^-24; zero/denormal -> 0.
    function automatic logic [90:0] fp_fix(input logic [15:0] h);
        logic [90:0] m;
        if (h[14:10] == 5'd0) return 91'd0;
        m = 91'({1'b1, h[9:0]});
        return m << (h[14:10] - 5'd1);
    endfunction

    function automatic acc_tile_t datapath(input fp_tile_t a, input fp_tile_t b,
                                           input acc_tile_t c, input bit mode);
        acc_tile_t r;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[i][j] = c[i][j];
                if (mode) begin
                    for (int k = 0; k < 4; k++)
                        r[i][j] = r[i][j] + ((fp_fix(a[i][k]) * fp_fix(b[k][j])) >> 24);
                end else begin
                    r[i][j] = r[i][j] + 91'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb gemm_result = datapath(gemm_a, gemm_b, gemm_c, int_mode);

    function automatic acc_tile_t acc_fill(input logic [90:0] v);
        acc_tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) t[i][j] = v;
        return t;
    endfunction

    function automatic fp_tile_t fp_fill(input logic [15:0] v);
        fp_tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) t[i][j] = v;
        return t;
    endfunction

    task automatic start_job(input logic [KW-1:0] k, input bit sel, input acc_tile_t ci);
        start = 1'b1; k_tiles = k; c_init_sel = sel; c_init = ci;
        @(posedge clk); #1;
        start = 1'b0; k_tiles = '0; c_init_sel = 1'b0; c_init = '0;
    endtask

    // cyc counts edges from the start-sampling edge (=1) until res_valid is seen.
    task automatic wait_valid(input int limit, output int cyc);
        cyc = 1;
        while (!res_valid && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if (busy !== 1'b0 || tile_ready !== 1'b0 || res_valid !== 1'b0 ||
            gemm_c !== '0 || gemm_a !== '0 || res_data !== '0 || tile_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b rdy=%b rv=%b cnt=%0d (expected all 0)",
                     busy, tile_ready, res_valid, tile_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_k3;
        int cyc, r0;
        acc_tile_t got;
        tile_valid = 1'b1; a_tile = fp_fill(16'h3C00); b_tile = fp_fill(16'h3C00);
        exp_q.push_back(acc_fill(91'd3));
        r0 = rdy_total;
        start_job(8'd3, 1'b0, acc_fill(91'd9));
        wait_valid(50, cyc);
        n_cmp++;
        if (cyc !== 7 || res_valid !== 1'b1) begin
            n_err++; $display("FAIL k3_latency: got %0d cycles rv=%b, expected 7", cyc, res_valid);
        end
        got = exp_q.pop_front();
        n_cmp++;
        if (res_data !== got) begin
            n_err++; $display("FAIL k3_data: elem00=%0d expected %0d", res_data[0][0], got[0][0]);
        end
        n_cmp++;
        if (tile_cnt !== 8'd3) begin
            n_err++; $display("FAIL k3_tile_cnt: got %0d expected 3", tile_cnt);
        end
        n_cmp++;
        if (rdy_total - r0 !== 3) begin
            n_err++; $display("FAIL k3_ready_pulses: got %0d expected 3", rdy_total - r0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL k3_after_hs: rv=%b busy=%b expected 0/0", res_valid, busy);
        end
    endtask

    task automatic test_cinit;
        int cyc;
        acc_tile_t got;
        exp_q.push_back(acc_fill(91'd102));
        start_job(8'd2, 1'b1, acc_fill(91'd100));
        wait_valid(50, cyc);
        got = exp_q.pop_front();
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== got) begin
            n_err++; $display("FAIL cinit_data: rv=%b elem33=%0d expected %0d",
                              res_valid, res_data[3][3], got[3][3]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_k0;
        int cyc, r0;
        acc_tile_t got;
        exp_q.push_back(acc_fill(91'd5));
        r0 = rdy_total;
        start_job(8'd0, 1'b1, acc_fill(91'd5));
        wait_valid(50, cyc);
        n_cmp++;
        if (cyc !== 1 || res_valid !== 1'b1) begin
            n_err++; $display("FAIL k0_latency: got %0d cycles rv=%b, expected 1", cyc, res_valid);
        end
        got = exp_q.pop_front();
        n_cmp++;
        if (res_data !== got || tile_cnt !== 8'd0) begin
            n_err++; $display("FAIL k0_data: elem12=%0d cnt=%0d expected %0d/0",
                              res_data[1][2], tile_cnt, got[1][2]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rdy_total - r0 !== 0) begin
            n_err++; $display("FAIL k0_ready: got %0d pulses expected 0", rdy_total - r0);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        acc_tile_t got, held;
        tile_valid = 1'b0; res_ready = 1'b0;
        exp_q.push_back(acc_fill(91'd2));
        start_job(8'd2, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (tile_ready !== 1'b1 || busy !== 1'b1 || tile_cnt !== 8'd0) begin
                n_err++; $display("FAIL bp_fetch_hold[%0d]: rdy=%b busy=%b cnt=%0d expected 1/1/0",
                                  i, tile_ready, busy, tile_cnt);
            end
        end
        tile_valid = 1'b1;
        wait_valid(50, cyc);
        held = res_data;
        got = exp_q.pop_front();
        n_cmp++;
        if (res_valid !== 1'b1 || held !== got || tile_cnt !== 8'd2) begin
            n_err++; $display("FAIL bp_data: rv=%b elem00=%0d cnt=%0d expected 1/%0d/2",
                              res_valid, held[0][0], tile_cnt, got[0][0]);
        end
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            @(posedge clk); #1;
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== held) begin
                n_err++; $display("FAIL bp_out_hold[%0d]: rv=%b elem00=%0d expected 1/%0d",
                                  i, res_valid, res_data[0][0], held[0][0]);
            end
        end
        start = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_start_ignored: busy=%b rv=%b expected 0/0", busy, res_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL bp_idle_stays: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_async_reset;
        tile_valid = 1'b1; a_tile = fp_fill(16'h3C00); b_tile = fp_fill(16'h3C00);
        start_job(8'd3, 1'b1, acc_fill(91'd7));
        @(posedge clk); #1;
        tile_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || tile_ready !== 1'b0 || res_valid !== 1'b0 || gemm_a !== '0 ||
            gemm_b !== '0 || gemm_c !== '0 || tile_cnt !== '0) begin
            n_err++; $display("FAIL async_reset: busy=%b rdy=%b rv=%b c00=%0d cnt=%0d expected zeros",
                              busy, tile_ready, res_valid, gemm_c[0][0], tile_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_integration;
        int cyc;
        real ar[4][4], br[4][4], s;
        acc_tile_t e, got;
        int_mode = 1'b1;
        tile_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a_tile[i][j] = (i == j) ? 16'h3C00 : 16'h0000;
                b_tile[i][j] = 16'h4000;
                ar[i][j] = (i == j) ? 1.0 : 0.0;
                br[i][j] = 2.0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0.0;
                for (int k = 0; k < 4; k++) s = s + ar[i][k] * br[k][j];
                e[i][j] = 91'(longint'(4.0 * s * 16777216.0));
            end
        end
        exp_q.push_back(e);
        start_job(8'd4, 1'b0, '0);
        wait_valid(50, cyc);
        got = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 9 || res_data !== got || tile_cnt !== 8'd4) begin
            n_err++; $display("FAIL integ_mma: cyc=%0d elem21=%0h cnt=%0d expected 9/%0h/4",
                              cyc, res_data[2][1], tile_cnt, got[2][1]);
        end
        @(posedge clk); #1;
        int_mode = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_k3();
        test_cinit();
        test_k0();
        test_backpressure();
        test_async_reset();
        test_integration();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tensor_core_kseq.md
Name: tensor_core_kseq

Overview:
- Sequencer for the combinational 4x4 FP16 MMA datapath `tensor_core_gemm`. It runs one K-loop job: accepts a stream of (A,B) 4x4 tile pairs over valid/ready and drives the datapath once per pair.
- Keeps the 4x4 Kulisch accumulator in registers, feeds it back as C, and presents the final C tile on a valid/ready result port.
- Sits between the tile fetch logic and `tensor_core_gemm`, which is instantiated beside it, not inside it.

Parameters:
- DWIDTH, 16, element width of A/B (FP16).
- AWIDTH, 91, Kulisch accumulator element width.
- KW, 8, width of the tile-count field; max job length is 2^KW-1 tiles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-high (despite the name).
- start  in  1  job start pulse; sampled only in IDLE.
- k_tiles  in  KW  number of tile pairs in the job; sampled with start.
- c_init_sel  in  1  1: accumulator starts from c_init; 0: starts from zero.
- c_init  in  [0:3][0:3][AWIDTH]  initial accumulator; sampled with start.
- busy  out  1  high whenever state != IDLE.
- tile_valid  in  1  A/B tile pair available.
- tile_ready  out  1  controller accepts a tile pair this cycle.
- a_tile, b_tile  in  [0:3][0:3][DWIDTH]  input tiles.
- gemm_a, gemm_b  out  [0:3][0:3][DWIDTH]  registered operands to the datapath.
- gemm_c  out  [0:3][0:3][AWIDTH]  accumulator to the datapath C_in.
- gemm_result  in  [0:3][0:3][AWIDTH]  datapath C_out, sampled in MAC.
- res_valid  out  1  final tile available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  [0:3][0:3][AWIDTH]  final accumulator.
- tile_cnt  out  KW  number of tiles consumed in the current or last job.

Behaviour:
- Reset (async, rst_n=1): state=IDLE. Accumulator, A/B operand regs, remaining counter and tile_cnt cleared to 0. Outputs: busy=0, tile_ready=0, res_valid=0; gemm_a, gemm_b, gemm_c and res_data are all zero. Reset mid-job abandons the job with no result.
- States: IDLE, FETCH, MAC, OUT.
- IDLE:
  - When start=1: remaining<=k_tiles, tile_cnt<=0, acc<=(c_init_sel ? c_init : 0).
  - Next state is OUT if k_tiles==0, else FETCH.
  - start=0 stays in IDLE.
- FETCH:
  - tile_ready=1.
  - On tile_valid&&tile_ready: a_reg<=a_tile, b_reg<=b_tile, go to MAC.
  - Otherwise stay; there is no timeout.
- MAC (exactly 1 cycle):
  - tile_ready=0. gemm_a=a_reg, gemm_b=b_reg, gemm_c=acc.
  - acc<=gemm_result, remaining<=remaining-1, tile_cnt<=tile_cnt+1.
  - Next state is OUT if remaining==1, else FETCH.
- OUT:
  - res_valid=1, res_data=acc; res_data is held stable while res_valid=1 and res_ready=0.
  - On res_ready, go to IDLE; res_valid is low the next cycle.
- Outputs:
  - gemm_a, gemm_b and gemm_c are driven continuously from registers (a_reg, b_reg, acc), so they are glitch-free.
  - res_data=acc in all states.
- Throughput/latency:
  - One tile pair per 2 cycles at best.
  - With tile_valid held high, a k-tile job takes start→res_valid = 2k+1 cycles.
  - k=0 gives res_valid 1 cycle after start.
- start while busy (including the OUT handshake cycle) is ignored; there is no queueing.
- k_tiles, c_init and c_init_sel are don't-care outside the start cycle.
- tile_ready is never high outside FETCH. A tile_valid that arrives early is held by the producer.
- The controller performs no arithmetic on accumulator data; rounding and width are owned by the datapath.

Decomposition:
- tensor_core_pkg holds:
  - DWIDTH/AWIDTH localparams.
  - Typedefs `fp_tile_t` ([0:3][0:3][DWIDTH-1:0]) and `acc_tile_t` ([0:3][0:3][AWIDTH-1:0]).
  - `kseq_state_t` enum {IDLE, FETCH, MAC, OUT}.
- Single module, no sub-module. `tensor_core_gemm` is instantiated by the parent and connected via the gemm_* ports.

Test Plan:
- Bench stub: gemm_result = gemm_c + 1 per element. Tiles use 1.0 (16'h3C00).
- Reset with outputs poked: assert rst_n mid-FETCH → busy=0, tile_ready=0, res_valid=0, all gemm_* =0, tile_cnt=0 immediately (async).
- k_tiles=3, c_init_sel=0, tile_valid always 1:
  - res_valid rises 7 cycles after start.
  - Every res_data element =3, tile_cnt=3.
  - tile_ready pulses 3 times.
- k_tiles=2, c_init_sel=1, c_init all =100: every result element =102.
- k_tiles=0, c_init all =5: res_valid 1 cycle after start, result =5, tile_ready never asserted.
- Backpressure:
  - tile_valid low for 4 cycles in FETCH → state holds, no count change.
  - res_ready low for 3 cycles in OUT → res_data stable, res_valid stays 1.
  - A start pulse during OUT is ignored: after the handshake, state is IDLE and busy=0.
- Real-datapath integration with `tensor_core_gemm`:
  - A = identity (3C00 on the diagonal), B = all 2.0 (16'h4000), k_tiles=4, c_init_sel=0.
  - Result equals a behavioural model of 4× the A·B product, element-wise.
